// File: rtl/tia_hclk_gen_pkg.sv
// Shared constants for the TIA horizontal clock generator.
// The decode values are not written out by hand. They are generated from the
// counter's own step rule, so the table and the counter cannot drift apart.
package tia_hclk_gen_pkg;

  // hclock states per line (57 * 4 = 228 colour clocks)
  localparam int HC_LINE_LEN = 57;

  // One step of the 6-bit polynomial counter: shift left, XNOR feedback.
  function automatic logic [5:0] lfsr6_next(input logic [5:0] q);
    return {q[4:0], ~(q[5] ^ q[4])};
  endfunction

  // Counter value reached 'idx' steps after 000000.
  function automatic logic [5:0] lfsr6_at(input int idx);
    logic [5:0] q;
    q = 6'b000000;
    for (int i = 0; i < idx; i++) begin
      q = lfsr6_next(q);
    end
    return q;
  endfunction

  // Line event decodes, expressed as counter values.
  localparam logic [5:0] HC_SHB  = lfsr6_at(0);   // start hblank
  localparam logic [5:0] HC_SHS  = lfsr6_at(4);   // start hsync
  localparam logic [5:0] HC_RHS  = lfsr6_at(8);   // reset hsync
  localparam logic [5:0] HC_RCB  = lfsr6_at(12);  // reset colour burst
  localparam logic [5:0] HC_RHB  = lfsr6_at(16);  // reset hblank
  localparam logic [5:0] HC_LRHB = lfsr6_at(18);  // late reset hblank
  // The line-end value depends on the line length, so the top derives it.

  // Phase values that drive the two DL latch strobes.
  localparam logic [1:0] HC_PH1  = 2'd0;
  localparam logic [1:0] HC_PH2  = 2'd2;
  localparam logic [1:0] PH_LAST = 2'd3;  // the counter steps on this edge

endpackage

// File: rtl/tia_hclk_gen_lfsr6.sv
// 6-bit polynomial (LFSR) horizontal counter.
// It advances only when 'step' is high. 'clr' turns that step into a load of 000000.
module tia_lfsr6
  import tia_hclk_gen_pkg::*;
(
  input  logic       clk,
  input  logic       r_n,
  input  logic       step,
  input  logic       clr,
  output logic [5:0] q
);

  logic [5:0] r_q;

  // Counter register: synchronous reset to 000000, then step or clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. The reset is
    // synchronous, so it sits inside the clocked branch and is not in the
    // sensitivity list.
    if (!r_n) begin
      r_q <= 6'b000000;
    end else if (step) begin
      r_q <= clr ? 6'b000000 : lfsr6_next(r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tia_hclk_gen.sv
// TIA horizontal clock generator.
// Divides the colour clock by 4 into the two-phase DL strobes hphi1/hphi2.
// Steps the polynomial line counter and decodes the hblank/hsync events.
// Also implements the WSYNC/RDY halt handshake and RSYNC.
// Every output is decoded from registered state only.
module tia_hclk_gen
  import tia_hclk_gen_pkg::*;
#(
  parameter int LINE_LEN = HC_LINE_LEN  // must be <= 63
) (
  input  logic       clk,
  input  logic       r_n,
  input  logic       wsync,
  input  logic       rsync,
  output logic       hphi1,
  output logic       hphi2,
  output logic       shb,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       rdy,
  output logic [5:0] hidx
);

  localparam logic [5:0] HC_END = lfsr6_at(LINE_LEN - 1);

  logic [1:0] r_ph;
  logic       r_rdy_q;
  logic       r_rsync_pend;
  logic [5:0] w_lfsr;
  logic       w_step;
  logic       w_clr;
  logic       w_line_start;

  // The counter moves only on the last phase of an hclock. It reloads to 0 on
  // line end, on an earlier rsync, or on an rsync that lands on this same edge.
  assign w_step       = (r_ph == PH_LAST);
  assign w_clr        = (w_lfsr == HC_END) | r_rsync_pend | rsync;
  assign w_line_start = w_step & w_clr;

  // Free-running phase divider; rsync does not touch it, so cadence is kept.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_ph <= 2'd0;
    end else begin
      r_ph <= r_ph + 2'd1;
    end
  end

  // Hold an rsync until the next step edge consumes it.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_rsync_pend <= 1'b0;
    end else if (w_step) begin
      r_rsync_pend <= 1'b0;
    end else if (rsync) begin
      r_rsync_pend <= 1'b1;
    end
  end

  // RDY handshake: wsync drops it and the next line start raises it.
  // A wsync on the line-start edge wins.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      r_rdy_q <= 1'b1;
    end else if (wsync) begin
      r_rdy_q <= 1'b0;
    end else if (w_line_start) begin
      r_rdy_q <= 1'b1;
    end
  end

  tia_lfsr6 u_lfsr (
    .clk  (clk),
    .r_n  (r_n),
    .step (w_step),
    .clr  (w_clr),
    .q    (w_lfsr)
  );

  // Each decode is held for the full 4-clk hclock of its index.
  // Each DL latch therefore sees one hphi1/hphi2 pair per pulse.
  assign hphi1 = (r_ph == HC_PH1);
  assign hphi2 = (r_ph == HC_PH2);
  assign shb   = (w_lfsr == HC_SHB);
  assign shs   = (w_lfsr == HC_SHS);
  assign rhs   = (w_lfsr == HC_RHS);
  assign rcb   = (w_lfsr == HC_RCB);
  assign rhb   = (w_lfsr == HC_RHB);
  assign lrhb  = (w_lfsr == HC_LRHB);
  assign rdy   = r_rdy_q;
  assign hidx  = w_lfsr;

endmodule

// File: tb/tb_tia_hclk_gen.sv
// Self-checking bench for tia_hclk_gen.
// The reference model tracks the line as a plain hclock index (0..56) plus a
// phase count, and maps index to counter value through a table built from the
// step rule.
module tb_tia_hclk_gen;

  localparam int LINE = 57;
  localparam int LINE_CLK = LINE * 4;

  logic       clk = 1'b0;
  logic       r_n;
  logic       wsync;
  logic       rsync;
  logic       hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, rdy;
  logic [5:0] hidx;

  always #5 clk = ~clk;

  tia_hclk_gen dut (
    .clk   (clk),
    .r_n   (r_n),
    .wsync (wsync),
    .rsync (rsync),
    .hphi1 (hphi1),
    .hphi2 (hphi2),
    .shb   (shb),
    .shs   (shs),
    .rhs   (rhs),
    .rcb   (rcb),
    .rhb   (rhb),
    .lrhb  (lrhb),
    .rdy   (rdy),
    .hidx  (hidx)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  logic [5:0] seq [LINE];
  int         m_idx = 0;
  int         m_ph  = 0;
  bit         m_rdy = 1'b1;
  bit         m_restart_req = 1'b0;

  logic [14:0] dut_vec;
  logic [5:0]  pulses;
  assign dut_vec = {hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, rdy, hidx};
  assign pulses  = {lrhb, rhb, rcb, rhs, shs, shb};

  function automatic logic [14:0] exp_vec();
    return {m_ph == 0, m_ph == 2, m_idx == 0, m_idx == 4, m_idx == 8,
            m_idx == 12, m_idx == 16, m_idx == 18, m_rdy, seq[m_idx]};
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    bit new_line;
    new_line = 1'b0;
    if (!r_n) begin
      m_ph = 0; m_idx = 0; m_rdy = 1'b1; m_restart_req = 1'b0;
    end else begin
      if (m_ph == 3) begin
        if (m_restart_req || rsync || m_idx == LINE - 1) begin
          m_idx = 0;
          new_line = 1'b1;
        end else begin
          m_idx = m_idx + 1;
        end
        m_restart_req = 1'b0;
      end else if (rsync) begin
        m_restart_req = 1'b1;
      end
      if (wsync) m_rdy = 1'b0;
      else if (new_line) m_rdy = 1'b1;
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  // Run until the model sits at the given index and phase (bounded).
  task automatic advance_to(input int idx, input int ph, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2 * LINE_CLK; n++) begin
      if (m_idx == idx && m_ph == ph) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    r_n = 1'b0; wsync = 1'b0; rsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      checks++;
    end
    // hphi1=1 hphi2=0 shb=1 others 0 rdy=1 hidx=0
    if (dut_vec !== 15'b101000001_000000) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 15'b101000001_000000);
    end
    checks++;
    r_n = 1'b1;
  endtask

  task automatic test_phase();
    for (int k = 1; k <= 40; k++) begin
      tick();
      if ({hphi1, hphi2} !== {k % 4 == 0, k % 4 == 2} || (hphi1 && hphi2)) begin
        errors++;
        $display("FAIL phase k=%0d got=%b%b exp=%b%b", k, hphi1, hphi2,
                 k % 4 == 0, k % 4 == 2);
      end
      checks++;
    end
  endtask

  task automatic test_free_run();
    int         off [6] = '{0, 16, 32, 48, 64, 72};
    int         rise_cyc [6] = '{-1, -1, -1, -1, -1, -1};
    int         last_shb = -1;
    logic [5:0] prev_p, cur_p;
    prev_p = pulses;
    for (int n = 0; n < 2 * LINE_CLK + 8; n++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL free_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      checks++;
      cur_p = pulses;
      for (int j = 0; j < 6; j++) begin
        if (cur_p[j] && !prev_p[j]) begin
          rise_cyc[j] = cyc;
          if (j == 0) begin
            if (last_shb >= 0) begin
              if (cyc - last_shb != LINE_CLK) begin
                errors++;
                $display("FAIL shb_period got=%0d exp=%0d", cyc - last_shb, LINE_CLK);
              end
              checks++;
            end
            last_shb = cyc;
          end else if (last_shb >= 0) begin
            if (cyc - last_shb != off[j]) begin
              errors++;
              $display("FAIL offset sig=%0d got=%0d exp=%0d", j, cyc - last_shb, off[j]);
            end
            checks++;
          end
        end
        if (!cur_p[j] && prev_p[j] && rise_cyc[j] >= 0) begin
          if (cyc - rise_cyc[j] != 4) begin
            errors++;
            $display("FAIL width sig=%0d got=%0d exp=4", j, cyc - rise_cyc[j]);
          end
          checks++;
        end
      end
      prev_p = cur_p;
    end
  endtask

  task automatic test_coverage();
    bit seen [64];
    int cnt;
    bit ok;
    cnt = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    advance_to(0, 0, ok);
    if (!ok) begin errors++; $display("FAIL cov_align timeout got=0 exp=1"); end
    checks++;
    for (int n = 0; n < LINE_CLK; n++) begin
      if (!seen[hidx]) begin seen[hidx] = 1'b1; cnt++; end
      tick();
    end
    if (cnt != LINE) begin
      errors++;
      $display("FAIL cov_distinct got=%0d exp=%0d", cnt, LINE);
    end
    checks++;
    if (hidx !== 6'b000000) begin
      errors++;
      $display("FAIL cov_wrap got=%b exp=000000", hidx);
    end
    checks++;
  endtask

  // Count the clocks rdy stays low after the current edge (bounded).
  task automatic measure_low(input string tag, input int exp_low);
    int low;
    low = (rdy === 1'b0) ? 1 : 0;
    for (int n = 0; n < 2 * LINE_CLK && rdy === 1'b0; n++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL %s_vec cyc=%0d got=%h exp=%h", tag, cyc, dut_vec, exp_vec());
      end
      checks++;
      if (rdy === 1'b0) low++;
    end
    if (low != exp_low) begin
      errors++;
      $display("FAIL %s_low got=%0d exp=%0d", tag, low, exp_low);
    end
    checks++;
    if (rdy !== 1'b1 || shb !== 1'b1) begin
      errors++;
      $display("FAIL %s_rise got rdy=%b shb=%b exp rdy=1 shb=1", tag, rdy, shb);
    end
    checks++;
  endtask

  task automatic test_wsync();
    bit ok;
    advance_to(20, 1, ok);
    if (!ok) begin errors++; $display("FAIL wsync_align timeout got=0 exp=1"); end
    checks++;
    wsync = 1'b1; tick(); wsync = 1'b0;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL wsync_drop got=%b exp=0", rdy);
    end
    checks++;
    // Low from ph2 of index 20 through the end of index LINE-1.
    measure_low("wsync", (LINE - 1 - 20) * 4 + 2);
  endtask

  task automatic test_rsync();
    bit ok;
    advance_to(30, 1, ok);
    if (!ok) begin errors++; $display("FAIL rsync_align timeout got=0 exp=1"); end
    checks++;
    rsync = 1'b1; tick(); rsync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rsync_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      checks++;
      tick();
    end
    // Phase went 1 -> 2 -> 3 -> 0; the restart lands on that first ph==0.
    if (hidx !== 6'b000000 || shb !== 1'b1 || hphi1 !== 1'b1 || hphi2 !== 1'b0) begin
      errors++;
      $display("FAIL rsync_load got hidx=%b shb=%b hphi=%b%b exp hidx=000000 shb=1 hphi=10",
               hidx, shb, hphi1, hphi2);
    end
    checks++;
  endtask

  task automatic test_wsync_on_wrap();
    bit ok;
    advance_to(LINE - 1, 3, ok);
    if (!ok) begin errors++; $display("FAIL wrap_align timeout got=0 exp=1"); end
    checks++;
    wsync = 1'b1; tick(); wsync = 1'b0;
    if (rdy !== 1'b0 || hidx !== 6'b000000) begin
      errors++;
      $display("FAIL wrap_wsync got rdy=%b hidx=%b exp rdy=0 hidx=000000", rdy, hidx);
    end
    checks++;
    measure_low("wrap", LINE_CLK);
  endtask

  task automatic test_reset_mid();
    bit ok;
    advance_to(25, 0, ok);
    if (!ok) begin errors++; $display("FAIL rmid_align timeout got=0 exp=1"); end
    checks++;
    wsync = 1'b1; tick(); wsync = 1'b0;
    rsync = 1'b1; tick(); rsync = 1'b0;
    r_n = 1'b0; tick(); r_n = 1'b1;
    if (rdy !== 1'b1 || hidx !== 6'b000000) begin
      errors++;
      $display("FAIL rmid got rdy=%b hidx=%b exp rdy=1 hidx=000000", rdy, hidx);
    end
    checks++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rmid_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      r_n   = ($urandom_range(0, 199) != 0);
      wsync = ($urandom_range(0, 29) == 0);
      rsync = ($urandom_range(0, 59) == 0);
      tick();
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_vec cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      checks++;
    end
    r_n = 1'b1; wsync = 1'b0; rsync = 1'b0;
  endtask

  initial begin
    logic [5:0] q;
    q = 6'b000000;
    for (int i = 0; i < LINE; i++) begin
      seq[i] = q;
      q = {q[4:0], ~(q[5] ^ q[4])};
    end
    r_n = 1'b0; wsync = 1'b0; rsync = 1'b0;
    test_reset();
    test_phase();
    test_free_run();
    test_coverage();
    test_wsync();
    test_rsync();
    test_wsync_on_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
